// File: rtl/pipeline_pkg.sv
// Shared fetch-pipeline definitions: datapath width and fetch FSM encoding.
package pipeline_pkg;
  localparam int DATA_WIDTH = 64;
  localparam int INST_WIDTH = 32;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } fetch_state_e;
endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: clear beats load, load beats hold; an unheld entry is consumed.
module if_id_reg
  import pipeline_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_load,
  input  logic                  i_clear,
  input  logic                  i_stall,
  input  logic [DATA_WIDTH-1:0] i_pc,
  input  logic [INST_WIDTH-1:0] i_inst,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_pc,
  output logic [INST_WIDTH-1:0] o_inst
);
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_pc;
  logic [INST_WIDTH-1:0] r_inst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_inst  <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_pc    <= i_pc;
      r_inst  <= i_inst;
    end else if (!(i_stall && r_valid)) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_pc    = r_pc;
  assign o_inst  = r_inst;
endmodule

// File: rtl/fetch_redirect.sv
// Instruction fetch with single outstanding request and redirect handling.
// A redirect that races an accepted request marks its response stale (DROP).
module fetch_redirect
  import pipeline_pkg::*;
#(
  parameter logic [DATA_WIDTH-1:0] RESET_PC = 64'h8000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_if,
  input  logic                  prediction_failed,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  input  logic                  stall,
  output logic                  req_valid,
  input  logic                  req_ready,
  output logic [DATA_WIDTH-1:0] req_pc,
  input  logic                  rsp_valid,
  input  logic [INST_WIDTH-1:0] rsp_inst,
  output logic                  if_valid,
  output logic [DATA_WIDTH-1:0] if_pc,
  output logic [INST_WIDTH-1:0] if_inst,
  output logic [31:0]           redirect_count
);
  localparam logic [DATA_WIDTH-1:0] INST_BYTES = DATA_WIDTH'(4);

  fetch_state_e          r_state;
  logic [DATA_WIDTH-1:0] r_pc;
  logic [DATA_WIDTH-1:0] r_inflight_pc;
  logic [31:0]           r_redirect_count;

  logic                  w_req_fire;
  logic                  w_rsp_take;
  logic                  w_if_clear;
  logic [DATA_WIDTH-1:0] w_next_seq_pc;

  // Request is withheld while decode is holding a valid instruction.
  assign req_valid      = (r_state == REQ) && !(if_valid && stall);
  assign req_pc         = r_pc;
  assign redirect_count = r_redirect_count;

  assign w_req_fire    = req_valid && req_ready;
  assign w_rsp_take    = (r_state == WAIT) && rsp_valid && !prediction_failed;
  assign w_if_clear    = flush_if || prediction_failed;
  assign w_next_seq_pc = r_inflight_pc + INST_BYTES;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state          <= BOOT;
      r_pc             <= RESET_PC;
      r_inflight_pc    <= RESET_PC;
      r_redirect_count <= '0;
    end else begin
      if (prediction_failed) begin
        r_redirect_count <= r_redirect_count + 32'd1;
      end
      case (r_state)
        BOOT: begin
          r_state <= REQ;
          r_pc    <= prediction_failed ? redirect_pc : RESET_PC;
        end
        REQ: begin
          if (prediction_failed) begin
            r_pc <= redirect_pc;
          end
          if (w_req_fire) begin
            r_inflight_pc <= r_pc;
            r_state       <= prediction_failed ? DROP : WAIT;
          end
        end
        WAIT: begin
          if (rsp_valid) begin
            r_state <= REQ;
            r_pc    <= prediction_failed ? redirect_pc : w_next_seq_pc;
          end else if (prediction_failed) begin
            r_state <= DROP;
            r_pc    <= redirect_pc;
          end
        end
        DROP: begin
          if (prediction_failed) begin
            r_pc <= redirect_pc;
          end
          if (rsp_valid) begin
            r_state <= REQ;
          end
        end
        default: r_state <= BOOT;
      endcase
    end
  end

  if_id_reg u_if_id_reg (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_rsp_take),
    .i_clear (w_if_clear),
    .i_stall (stall),
    .i_pc    (r_inflight_pc),
    .i_inst  (rsp_inst),
    .o_valid (if_valid),
    .o_pc    (if_pc),
    .o_inst  (if_inst)
  );
endmodule

// File: doc/fetch_redirect.md
FETCH_REDIRECT -- requirements
Module: fetch_redirect

Interface
REQ-001 Parameter RESET_PC, default 64'h8000_0000, first fetch address after reset.
REQ-002 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port rst  input  1  asynchronous, active-high reset.
REQ-004 Port flush_if  input  1  squash fetch stage (from flush unit).
REQ-005 Port prediction_failed  input  1  redirect request; qualifies redirect_pc.
REQ-006 Port redirect_pc  input  DATA_WIDTH  corrected next PC.
REQ-007 Port stall  input  1  decode cannot accept; hold IF/ID register.
REQ-008 Port req_valid  output  1  instruction memory request.
REQ-009 Port req_ready  input  1  memory accepts request this cycle.
REQ-010 Port req_pc  output  DATA_WIDTH  request address.
REQ-011 Port rsp_valid  input  1  instruction data returned; no backpressure.
REQ-012 Port rsp_inst  input  32  returned instruction word.
REQ-013 Ports if_valid/if_pc/if_inst  output  1/DATA_WIDTH/32  registered IF/ID payload.
REQ-014 Port redirect_count  output  32  wrapping count of accepted redirects.

Function
REQ-015 FSM states SHALL be BOOT, REQ, WAIT, DROP.
REQ-016 BOOT: req_valid=0; next cycle SHALL enter REQ with pc_q=RESET_PC.
REQ-017 REQ: req_valid=1, req_pc=pc_q; req_valid SHALL be suppressed while if_valid=1 and stall=1.
REQ-018 REQ with req_valid&req_ready SHALL go to WAIT and latch pc_q as inflight_pc.
REQ-019 WAIT with rsp_valid SHALL load if_valid=1, if_pc=inflight_pc, if_inst=rsp_inst, set pc_q=inflight_pc+4, go to REQ.
REQ-020 At most one request SHALL be outstanding; a response is accepted only in WAIT or DROP.
REQ-021 prediction_failed SHALL set pc_q=redirect_pc and increment redirect_count by 1 (wraps 2^32-1 -> 0).
REQ-022 Redirect in REQ without handshake: req_pc SHALL switch to redirect_pc next cycle; state stays REQ.
REQ-023 Redirect in REQ coinciding with handshake: state SHALL go to DROP (accepted request is stale).
REQ-024 Redirect in WAIT without rsp_valid: SHALL go to DROP; with rsp_valid same cycle: response discarded, go to REQ.
REQ-025 DROP: next rsp_valid SHALL be discarded (if_* unchanged), then REQ at redirected pc_q; further redirects in DROP only update pc_q.
REQ-026 flush_if or prediction_failed SHALL clear if_valid next cycle, overriding stall and any same-cycle response load.
REQ-027 stall=1 with if_valid=1 SHALL hold if_pc/if_inst; a response arriving then SHALL NOT occur (REQ-017 guarantees).
REQ-028 stall=0 with no new response SHALL clear if_valid (decode consumed it).
REQ-029 PC arithmetic SHALL be DATA_WIDTH modulo; pc_q+4 wraps at 2^DATA_WIDTH.
REQ-030 flush_if without prediction_failed SHALL NOT change pc_q or FSM state.

Reset
REQ-031 rst SHALL asynchronously force: state=BOOT, pc_q=RESET_PC, req_valid=0, req_pc=RESET_PC, if_valid=0, if_pc=0, if_inst=0, redirect_count=0.
REQ-032 Reset asserted in WAIT SHALL abandon the in-flight request; a later rsp_valid while in BOOT SHALL be ignored.

Structure
REQ-033 DATA_WIDTH and the FSM state enum (fetch_state_e) SHALL live in pipeline_pkg.
REQ-034 Single module; IF/ID output register may be a sub-module if_id_reg (load/hold/clear).

Verification
REQ-035 Reset release, req_ready=1, rsp 1 cycle later -> req_pc 0x8000_0000, then 0x8000_0004; if_pc follows.
REQ-036 Redirect to 0x8000_0100 in WAIT before rsp -> next rsp dropped, next req_pc 0x8000_0100, redirect_count=1.
REQ-037 Redirect coincident with rsp_valid in WAIT -> if_valid=0, req_pc=redirect_pc next cycle.
REQ-038 stall=1 for 3 cycles with if_valid=1 -> if_* stable, req_valid=0; release -> fetch resumes at if_pc+4.
REQ-039 flush_if pulse during stall -> if_valid=0 next cycle, pc_q unchanged.
REQ-040 rst asserted mid-WAIT then late rsp_valid -> no if_valid; first req_pc=RESET_PC; redirect_count=0.
